// File: rtl/led_shift_writer_pkg.sv
// Shared types and default geometry for the LED / segment shift-register writer.
package led_shift_pkg;

   // Cascaded register length and half-period of the generated shift clock.
   localparam int DEFAULT_WIDTH = 24;
   localparam int DEFAULT_DIV   = 2;

   // Frame sequencer states: wait for a word, clock it out, pulse the latch.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

endpackage

// File: rtl/led_shift_writer_shift_tick_gen.sv
// Divide counter for the shift clock: emits a one-cycle tick every DIV cycles
// while enabled. Each tick marks a half-period boundary of LED_sclk.
module shift_tick_gen #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(DIV) + 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // The tick is decoded from the counter register; it is only used internally.
   assign tick = en && (cnt == LAST);

   // Count 0..DIV-1 while enabled; an accept or idle period restarts the phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || !en) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/led_shift_writer.sv
// Serial writer for cascaded shift registers: takes a parallel word over a
// valid/ready handshake, shifts it out MSB-first on a generated clock, then
// pulses the storage latch so all register outputs update together.
//
// Handshake: a frame is accepted on a rising clk edge where wr_en && ready.
// ready is high only in IDLE; wr_en at any other time is ignored and wr_data
// is sampled solely at the accepting edge.
module led_shift_writer
   import led_shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DIV   = DEFAULT_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             ready,
   output logic             done,
   output logic             LED_data,
   output logic             LED_sclk,
   output logic             LED_latch,
   output state_t           dbg_state
);

   localparam int BW = $clog2(WIDTH) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sreg, sreg_nxt;
   logic [BW-1:0]    bit_cnt, bit_nxt;
   logic             latch_half, half_nxt;
   logic             sclk_nxt, latch_nxt, ready_nxt, done_nxt;
   logic             accept;
   logic             tick;

   // The MSB of the shift register is the pin; it is cleared on the way back
   // to IDLE so the data line rests low between frames.
   assign LED_data  = sreg[WIDTH-1];
   assign dbg_state = state;

   assign accept = (state == IDLE) && wr_en;

   shift_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state != IDLE),
      .clr  (accept),
      .tick (tick)
   );

   // Next-state and next-output decode; every output comes from a flop.
   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      bit_nxt   = bit_cnt;
      half_nxt  = latch_half;
      sclk_nxt  = LED_sclk;
      latch_nxt = LED_latch;
      ready_nxt = ready;
      done_nxt  = 1'b0;

      case (state)
         IDLE: begin
            if (wr_en) begin
               state_nxt = SHIFT;
               sreg_nxt  = wr_data;
               bit_nxt   = '0;
               sclk_nxt  = 1'b0;
               ready_nxt = 1'b0;
            end
         end

         SHIFT: begin
            if (tick) begin
               if (!LED_sclk) begin
                  // End of low phase: data has had DIV cycles of setup.
                  sclk_nxt = 1'b1;
               end else begin
                  // End of high phase: the only point where data may move.
                  sclk_nxt = 1'b0;
                  if (bit_cnt == LAST_BIT) begin
                     state_nxt = LATCH;
                     latch_nxt = 1'b1;
                     half_nxt  = 1'b0;
                  end else begin
                     bit_nxt  = bit_cnt + BW'(1);
                     sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
                  end
               end
            end
         end

         LATCH: begin
            // Latch stays high for two tick periods, i.e. one full sclk period.
            if (tick) begin
               if (!latch_half) begin
                  half_nxt = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  half_nxt  = 1'b0;
                  latch_nxt = 1'b0;
                  sreg_nxt  = '0;
                  ready_nxt = 1'b1;
                  done_nxt  = 1'b1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            sreg_nxt  = '0;
            sclk_nxt  = 1'b0;
            latch_nxt = 1'b0;
            ready_nxt = 1'b1;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath and pin registers; reset drops every pin at once mid-frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg       <= '0;
         bit_cnt    <= '0;
         latch_half <= 1'b0;
         LED_sclk   <= 1'b0;
         LED_latch  <= 1'b0;
         ready      <= 1'b1;
         done       <= 1'b0;
      end else begin
         sreg       <= sreg_nxt;
         bit_cnt    <= bit_nxt;
         latch_half <= half_nxt;
         LED_sclk   <= sclk_nxt;
         LED_latch  <= latch_nxt;
         ready      <= ready_nxt;
         done       <= done_nxt;
      end
   end

endmodule

// File: doc/led_shift_writer.md
# led_shift_writer

Serial transmitter for the board's cascaded shift-register outputs (LED bank and segment drivers): the write-side counterpart of the DIP switch serial reader. Accepts a parallel word over a valid/ready handshake, shifts it out MSB-first on a generated shift clock, then pulses a storage latch so all outputs update at once. Sits between the register file / display logic and the board output pins.

## Interface
- WIDTH, 24: bits per frame (cascaded register length), ≥ 2
- DIV, 2: system clock cycles per half period of LED_sclk, ≥ 1
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  write request; frame accepted when wr_en && ready
- wr_data  input  WIDTH  frame to transmit, captured on accept
- ready  output  1  high when idle and able to accept a frame
- done  output  1  one-cycle pulse when a frame's latch pulse completes
- LED_data  output  1  serial data to first register in chain
- LED_sclk  output  1  shift clock; registers sample on its rising edge
- LED_latch  output  1  storage latch, active-high, rising edge transfers shifted data to outputs

## Operation
- Reset values: ready=1, done=0, LED_data=0, LED_sclk=0, LED_latch=0, state IDLE, counters 0.
- States: IDLE -> SHIFT -> LATCH -> IDLE.
- IDLE: ready=1. On wr_en: capture wr_data into shift register, bit counter=0, divide counter=0, go SHIFT, ready=0.
- SHIFT: each bit occupies 2*DIV cycles: LED_sclk low for DIV cycles, high for DIV cycles. LED_data presents wr_data[WIDTH-1-n] for bit n for its full low and high phases; changes only at the sclk high->low boundary. After bit WIDTH-1's high phase: LED_sclk=0, go LATCH.
- LATCH: LED_sclk=0, LED_data holds last bit, LED_latch=1 for 2*DIV cycles, then LED_latch=0, go IDLE, done=1 for exactly that first IDLE cycle.
- wr_en while ready=0 is ignored; wr_data is not re-sampled mid-frame.
- Back-to-back: wr_en high in the cycle done=1 (ready=1) is accepted; the next frame starts without extra idle cycles.
- Reset mid-frame: all outputs return to reset values immediately; no latch pulse is issued for the aborted frame; done not asserted.
- LED_data returns to 0 in IDLE.

## Timing
- Accept at edge k: first SHIFT cycle is k+1; LED_sclk first rises at k+1+DIV.
- Frame length from accept to done: WIDTH*2*DIV + 2*DIV cycles (100 for defaults); done high in cycle k+101, ready=1 same cycle.
- Data setup/hold to LED_sclk rising edge: DIV cycles each.
- All outputs registered; no combinational path from inputs to pins.
- Divide counter width clog2(DIV)+1; bit counter width clog2(WIDTH)+1; no wrap past WIDTH-1.

## Structure
- Package led_shift_pkg: state enum (IDLE, SHIFT, LATCH), default WIDTH/DIV constants.
- Sub-module shift_tick_gen: divide counter producing one-cycle phase-toggle ticks every DIV cycles, enabled only outside IDLE, cleared on accept and rst.
- Top holds FSM, shift register, bit counter, output registers.

## Test plan
- Reset then wr_data=24'hA5_3C_0F, wr_en one cycle -> 24 sclk rising edges, sampled serial stream MSB-first equals 0xA53C0F, one latch pulse of 4 cycles after last fall, done at accept+101.
- DIV=1, WIDTH=8, wr_data=8'h81 -> sclk period 2 cycles, bits 1,0,0,0,0,0,0,1, done at accept+19.
- wr_en held high continuously with changing wr_data -> only frames presented when ready=1 captured; second frame first sclk rise exactly 1+DIV cycles after done.
- wr_en pulsed during SHIFT with different data -> ignored; transmitted stream and done timing unchanged.
- rst asserted after 10 bits -> outputs immediately 0, ready=1, no LED_latch pulse, no done; new frame afterwards transmits correctly.
- Data stability check: LED_data never changes while LED_sclk=1 nor within DIV cycles before a rising edge, across all scenarios.
